// File: rtl/toggle_cover_collector.sv
// Toggle-coverage hit collector: keeps a sticky per-point hit bitmap and unique-hit count,
// streams the bitmap out over a valid/ready dump port and clears it one word per cycle.
module toggle_cover_collector #(
    parameter  int COVER_TOTAL = 1024,
    parameter  int WORD_W      = 32,
    parameter  int IDX_W       = 16,
    localparam int NWORDS      = (COVER_TOTAL + WORD_W - 1) / WORD_W,
    localparam int ADDR_W      = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hit_valid,
    input  logic [IDX_W-1:0]  hit_index,
    input  logic [1:0]        hit_mask,
    input  logic              dump_start,
    input  logic              clear_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [WORD_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              busy,
    output logic [IDX_W:0]    cover_count,
    output logic              range_err
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W:0] P_LIMIT = (IDX_W + 1)'(COVER_TOTAL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUMP,
        S_CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [WORD_W-1:0]   r_mem [NWORDS];
    logic [IDX_W:0]      r_cover_count;
    logic                r_range_err;

    logic [IDX_W:0]      w_p0;
    logic [IDX_W:0]      w_p1;
    logic                w_in0;
    logic                w_in1;
    logic [ADDR_W-1:0]   w_word0;
    logic [ADDR_W-1:0]   w_word1;
    logic [BIT_W-1:0]    w_bit0;
    logic [BIT_W-1:0]    w_bit1;
    logic                w_recording;
    logic                w_flag0;
    logic                w_flag1;
    logic                w_new0;
    logic                w_new1;
    logic                w_oor;
    logic                w_last_addr;
    logic [WORD_W-1:0]   w_word_mask;

    // Point indices are widened by one bit so hit_index+1 never wraps back into range.
    assign w_p0        = {1'b0, hit_index};
    assign w_p1        = w_p0 + 1'b1;
    assign w_in0       = (w_p0 < P_LIMIT);
    assign w_in1       = (w_p1 < P_LIMIT);
    assign w_word0     = ADDR_W'(w_p0 / WORD_W);
    assign w_word1     = ADDR_W'(w_p1 / WORD_W);
    assign w_bit0      = BIT_W'(w_p0 % WORD_W);
    assign w_bit1      = BIT_W'(w_p1 % WORD_W);
    assign w_recording = (r_state != S_CLEAR);
    assign w_flag0     = w_recording && hit_valid && hit_mask[0];
    assign w_flag1     = w_recording && hit_valid && hit_mask[1];
    assign w_last_addr = (r_addr == ADDR_W'(NWORDS - 1));

    // The bitmap read is only meaningful for in-range points; out-of-range reads are masked off.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_new0 = 1'b0;
        w_new1 = 1'b0;
        if (w_flag0 && w_in0) w_new0 = ~r_mem[w_word0][w_bit0];
        if (w_flag1 && w_in1) w_new1 = ~r_mem[w_word1][w_bit1];
        w_oor = (w_flag0 && !w_in0) || (w_flag1 && !w_in1);
    end

    always_comb begin
        w_word_mask = '0;
        for (int k = 0; k < WORD_W; k++) begin
            w_word_mask[k] = ((int'(r_addr) * WORD_W + k) < COVER_TOTAL);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (clear_start) begin
                    w_state_next = S_CLEAR;
                    w_addr_next  = '0;
                end else if (dump_start) begin
                    w_state_next = S_DUMP;
                    w_addr_next  = '0;
                end
            end
            S_DUMP: begin
                if (dump_ready) begin
                    if (w_last_addr) begin
                        w_state_next = S_IDLE;
                        w_addr_next  = '0;
                    end else begin
                        w_addr_next = r_addr + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (w_last_addr) begin
                    w_state_next = S_IDLE;
                    w_addr_next  = '0;
                end else begin
                    w_addr_next = r_addr + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_addr_next  = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
        end
    end

    // NOTE: the bitmap lives in flops and must read all-zero after reset, so it is reset like any register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NWORDS; w++) r_mem[w] <= '0;
        end else if (r_state == S_CLEAR) begin
            r_mem[r_addr] <= '0;
        end else begin
            if (w_flag0 && w_in0) r_mem[w_word0][w_bit0] <= 1'b1;
            if (w_flag1 && w_in1) r_mem[w_word1][w_bit1] <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cover_count <= '0;
            r_range_err   <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            if (w_last_addr) begin
                r_cover_count <= '0;
                r_range_err   <= 1'b0;
            end
        end else begin
            r_cover_count <= r_cover_count + (IDX_W + 1)'(w_new0) + (IDX_W + 1)'(w_new1);
            if (w_oor) r_range_err <= 1'b1;
        end
    end

    assign dump_valid  = (r_state == S_DUMP);
    assign dump_last   = (r_state == S_DUMP) && w_last_addr;
    assign dump_addr   = r_addr;
    assign dump_data   = r_mem[r_addr] & w_word_mask;
    assign busy        = (r_state != S_IDLE);
    assign cover_count = r_cover_count;
    assign range_err   = r_range_err;

endmodule

// File: doc/toggle_cover_collector.md
Name: toggle_cover_collector

Overview:
- Receiving end of the toggle-coverage hit stream: each cycle, a coverage point group presents a base cover index plus a 2-bit hit mask.
- The block keeps a sticky per-point hit bitmap and a running count of unique points covered.
- It exposes a handshaked dump port that streams the bitmap out word by word, and a multi-cycle clear sequence.
- It sits between the DUT-side toggle cover points and the fuzzing/BMC feedback harness, replacing the DPI callback path in synthesizable builds.

Parameters:
- COVER_TOTAL, 1024, number of cover points tracked; indices 0..COVER_TOTAL-1 are valid.
- WORD_W, 32, dump word width in bits.
- IDX_W, 16, width of hit_index; must satisfy 2^IDX_W > COVER_TOTAL.
- NWORDS, ceil(COVER_TOTAL/WORD_W), derived localparam; dump and clear length in words.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- hit_valid  in  1  hit group present this cycle.
- hit_index  in  IDX_W  cover index of hit_mask[0]; hit_mask[1] maps to hit_index+1.
- hit_mask  in  2  per-point hit flags.
- dump_start  in  1  one-cycle request to begin a dump; honoured only in IDLE.
- clear_start  in  1  one-cycle request to clear the bitmap; honoured only in IDLE.
- dump_valid  out  1  dump word valid.
- dump_ready  in  1  consumer accepts the dump word.
- dump_data  out  WORD_W  bitmap word; bit k = point dump_addr*WORD_W+k.
- dump_addr  out  clog2(NWORDS)  word index of dump_data.
- dump_last  out  1  asserted with the word at NWORDS-1.
- busy  out  1  state is not IDLE.
- cover_count  out  IDX_W+1  number of unique points hit since the last reset or clear.
- range_err  out  1  sticky; set when a flagged point index is >= COVER_TOTAL.

Behaviour:
- Reset (async assert, sync release): state=IDLE, bitmap all 0, cover_count=0, range_err=0, dump_valid=0, dump_addr=0, dump_last=0, busy=0.
- Hit recording (IDLE and DUMP states):
  - For each i in {0,1} with hit_valid && hit_mask[i], point p = hit_index+i is computed at IDX_W+1 bits, so there is no wrap.
  - If p < COVER_TOTAL, bitmap[p] is set at the next edge.
  - If p >= COVER_TOTAL, the point is dropped and range_err is set.
- Unique count:
  - cover_count increments next edge by popcount of the points that are in range and previously 0 (0, 1 or 2).
  - Repeat hits never increment the count.
  - The two points of one group may lie in different words.
- States: IDLE, DUMP, CLEAR. If dump_start and clear_start are asserted together in IDLE, CLEAR wins.
- IDLE -> DUMP on dump_start:
  - dump_addr=0; dump_valid rises the cycle after dump_start.
  - dump_data is the registered bitmap word, sampled combinationally from the current bitmap while valid.
  - Payload stays stable while dump_valid && !dump_ready, except bits set by concurrent hits. Those bits may appear; cleared bits never disappear.
  - On dump_valid && dump_ready: if dump_last, go to IDLE with dump_valid=0 next cycle; else dump_addr+1.
  - Bits of the last word at positions >= COVER_TOTAL always read 0.
- IDLE -> CLEAR on clear_start:
  - One word is zeroed per cycle, addr 0..NWORDS-1, so CLEAR lasts exactly NWORDS cycles.
  - Then cover_count=0 and range_err=0 in the final cycle, and the block returns to IDLE.
  - Hits arriving during CLEAR are discarded; they set no bits and do not change the count.
- dump_start or clear_start outside IDLE is ignored, not queued.
- Reset asserted mid-DUMP or mid-CLEAR aborts immediately to reset values.
- Hit handling latency: 1 cycle, bitmap and count visible the cycle after hit_valid.

Test Plan:
- Reset, hit_valid=1, hit_index=5, hit_mask=2'b11 -> next cycle cover_count=2; repeat the same hit -> cover_count stays 2.
- hit_index=31, mask=2'b11 with WORD_W=32 -> dump word0 bit31=1, word1 bit0=1, cover_count=2.
- hit_index=1023, mask=2'b11, COVER_TOTAL=1024 -> cover_count=1, range_err=1; last dump word bit31=1 and no out-of-range bit appears.
- Dump with dump_ready toggled 1,0,0,1 per cycle -> 32 words, dump_addr 0..31 in order, each word held while not ready, dump_last only on addr 31, busy=0 the cycle after the last handshake.
- clear_start after hits -> busy for exactly 32 cycles, hits injected during CLEAR are not recorded, then cover_count=0, range_err=0, and the following dump is all zero.
- Assert reset mid-dump at addr 10 -> dump_valid=0, state IDLE, cover_count=0 immediately; the next dump_start restarts at addr 0.
